// File: rtl/vae_pkg.sv
// Shared fixed-point constants, LFSR settings and helpers for the VAE datapath blocks.
package vae_pkg;

    localparam int WIDTH     = 10;
    localparam int FRAC_BITS = 4;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam logic signed [6:0] EPS_OFFSET = 7'sd30;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Taps for x^16+x^14+x^13+x^11+1 sit on bits 15,13,12,10 of a left-shifting register.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Sum of four uniform nibbles is roughly bell-shaped; re-centred to -30..30.
    function automatic logic signed [6:0] eps_from_lfsr(input logic [15:0] s);
        logic [5:0] nib_sum;
        nib_sum = {2'b00, s[15:12]} + {2'b00, s[11:8]} + {2'b00, s[7:4]} + {2'b00, s[3:0]};
        eps_from_lfsr = $signed({1'b0, nib_sum}) - EPS_OFFSET;
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        logic signed [32:0] sum;
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        sum   = {a[31], a} + {b[31], b};
        max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (w - 1));
        if (sum > max_v) begin
            sat_add = max_v[31:0];
        end else if (sum < min_v) begin
            sat_add = min_v[31:0];
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/vae_sigma_lut.sv
// Combinational sigma = round(2^F * exp((logvar>>>1)/2^F)) lookup over the clamped half-logvar.
module vae_sigma_lut
    import vae_pkg::*;
#(
    parameter int width     = WIDTH,
    parameter int frac_bits = FRAC_BITS
) (
    input  logic signed [width-1:0] logvar,
    output logic        [width-1:0] sigma
);

    localparam int H_LO      = -(2 << frac_bits);
    localparam int H_HI      = (2 << frac_bits) - 1;
    localparam int SIGMA_MAX = (1 << (width - 1)) - 1;

    // Entries are for frac_bits=4, index 0 corresponds to h=-32 and index 63 to h=31.
    localparam logic [7:0] SIGMA_ROM [0:63] = '{
        8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,
        8'd4,   8'd4,   8'd4,   8'd4,   8'd5,   8'd5,   8'd5,   8'd6,
        8'd6,   8'd6,   8'd7,   8'd7,   8'd8,   8'd8,   8'd9,   8'd9,
        8'd10,  8'd10,  8'd11,  8'd12,  8'd12,  8'd13,  8'd14,  8'd15,
        8'd16,  8'd17,  8'd18,  8'd19,  8'd21,  8'd22,  8'd23,  8'd25,
        8'd26,  8'd28,  8'd30,  8'd32,  8'd34,  8'd36,  8'd38,  8'd41,
        8'd43,  8'd46,  8'd49,  8'd52,  8'd56,  8'd59,  8'd63,  8'd67,
        8'd72,  8'd76,  8'd81,  8'd86,  8'd92,  8'd98,  8'd104, 8'd111
    };

    logic signed [width-1:0] h;
    logic signed [5:0]       h_clamped;
    logic        [5:0]       rom_idx;
    logic        [7:0]       rom_val;

    always_comb begin
        h = logvar >>> 1;
        if (int'(h) < H_LO) begin
            h_clamped = -6'sd32;
        end else if (int'(h) > H_HI) begin
            h_clamped = 6'sd31;
        end else begin
            h_clamped = h[5:0];
        end
        rom_idx = {~h_clamped[5], h_clamped[4:0]};
        rom_val = SIGMA_ROM[rom_idx];
        if (int'(rom_val) > SIGMA_MAX) begin
            sigma = width'(SIGMA_MAX);
        end else begin
            sigma = width'(rom_val);
        end
    end

endmodule

// File: rtl/vae_latent_sampler.sv
// Reparameterisation sampler: z[i] = sat(mu[i] + (sigma(logvar[i]) * eps) >>> F), one dimension per cycle.
module vae_latent_sampler
    import vae_pkg::*;
#(
    parameter int          latent_number = 2,
    parameter int          width         = WIDTH,
    parameter int          frac_bits     = FRAC_BITS,
    parameter logic [15:0] seed          = LFSR_DEFAULT_SEED
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    sample_en,
    input  logic signed [width-1:0] mu     [0:latent_number-1],
    input  logic signed [width-1:0] logvar [0:latent_number-1],
    output logic signed [width-1:0] z      [0:latent_number-1],
    output logic                    finish
);

    localparam int                IDX_W    = (latent_number > 1) ? $clog2(latent_number) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(latent_number - 1);
    localparam logic [15:0]       SEED_EFF = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

    logic [1:0]              state_q,  state_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic                    finish_q, finish_d;
    logic [15:0]             lfsr_q,   lfsr_d;
    logic                    sample_q, sample_d;
    logic signed [width-1:0] z_q      [0:latent_number-1];
    logic signed [width-1:0] z_d      [0:latent_number-1];
    logic signed [width-1:0] mu_q     [0:latent_number-1];
    logic signed [width-1:0] mu_d     [0:latent_number-1];
    logic signed [width-1:0] logvar_q [0:latent_number-1];
    logic signed [width-1:0] logvar_d [0:latent_number-1];

    logic        [width-1:0] sigma;
    logic signed [6:0]       eps;
    logic signed [width+6:0] sigma_x;
    logic signed [width+6:0] eps_x;
    logic signed [width+6:0] prod;
    logic signed [width+6:0] t;
    logic signed [width-1:0] z_new;

    vae_sigma_lut #(
        .width     (width),
        .frac_bits (frac_bits)
    ) u_sigma_lut (
        .logvar (logvar_q[idx_q]),
        .sigma  (sigma)
    );

    // Datapath for the dimension currently selected by idx; sigma is never negative.
    always_comb begin
        eps     = sample_q ? eps_from_lfsr(lfsr_q) : 7'sd0;
        sigma_x = {7'b0, sigma};
        eps_x   = {{width{eps[6]}}, eps};
        prod    = sigma_x * eps_x;
        t       = prod >>> frac_bits;
        z_new   = width'(sat_add(32'(mu_q[idx_q]), 32'(t), width));
    end

    // finish rises on the cycle after the last z write so the layer latency is latent_number+2.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        finish_d = finish_q;
        lfsr_d   = lfsr_q;
        sample_d = sample_q;
        z_d      = z_q;
        mu_d     = mu_q;
        logvar_d = logvar_q;
        case (state_q)
            ST_IDLE: begin
                finish_d = 1'b0;
                if (enable) begin
                    mu_d     = mu;
                    logvar_d = logvar;
                    sample_d = sample_en;
                    idx_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                z_d[idx_q] = z_new;
                if (sample_q) begin
                    lfsr_d = lfsr_next(lfsr_q);
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                finish_d = 1'b1;
                if (finish_q && !enable) begin
                    finish_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            finish_q <= 1'b0;
            lfsr_q   <= SEED_EFF;
            sample_q <= 1'b0;
            for (int i = 0; i < latent_number; i++) begin
                z_q[i]      <= '0;
                mu_q[i]     <= '0;
                logvar_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            finish_q <= finish_d;
            lfsr_q   <= lfsr_d;
            sample_q <= sample_d;
            z_q      <= z_d;
            mu_q     <= mu_d;
            logvar_q <= logvar_d;
        end
    end

    assign z      = z_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_vae_latent_sampler.sv
// Scoreboard bench for vae_latent_sampler: directed runs push expected z, a monitor checks on finish rise.
module tb_vae_latent_sampler;

    logic                clk;
    logic                rst_n;
    logic                enable;
    logic                sample_en;
    logic signed [9:0]   mu     [0:1];
    logic signed [9:0]   logvar [0:1];
    logic signed [9:0]   z      [0:1];
    logic                finish;

    typedef struct {
        logic signed [9:0] z0;
        logic signed [9:0] z1;
        int                start_cyc;
        string             name;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   check_count = 0;
    int   pass_count  = 0;
    int   cyc         = 0;
    logic finish_prev = 1'b0;

    vae_latent_sampler #(
        .latent_number (2),
        .width         (10),
        .frac_bits     (4),
        .seed          (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sample_en (sample_en),
        .mu        (mu),
        .logvar    (logvar),
        .z         (z),
        .finish    (finish)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count = check_count + 1;
        if (actual == expected) begin
            pass_count = pass_count + 1;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: each rising finish retires the oldest expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            finish_prev = 1'b0;
        end else begin
            if (finish && !finish_prev) begin
                checkOutput("sb_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    checkOutput({mon_e.name, "_z0"}, int'(z[0]), int'(mon_e.z0));
                    checkOutput({mon_e.name, "_z1"}, int'(z[1]), int'(mon_e.z1));
                    checkOutput({mon_e.name, "_latency"}, cyc - mon_e.start_cyc, 4);
                end
            end
            finish_prev = finish;
        end
    end

    task automatic doReset();
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    // mode 0: hold enable until finish; 1: drop enable after the start edge; 2: keep enable high past finish
    task automatic applyStimulus(input string name,
                                 input logic signed [9:0] m0, input logic signed [9:0] m1,
                                 input logic signed [9:0] l0, input logic signed [9:0] l1,
                                 input logic se,
                                 input logic signed [9:0] e0, input logic signed [9:0] e1,
                                 input int mode);
        exp_t e;
        @(negedge clk);
        mu[0]     = m0;
        mu[1]     = m1;
        logvar[0] = l0;
        logvar[1] = l1;
        sample_en = se;
        enable    = 1'b1;
        e.z0 = e0;
        e.z1 = e1;
        e.start_cyc = cyc;
        e.name = name;
        sb.push_back(e);
        if (mode == 1) begin
            @(negedge clk);
            enable    = 1'b0;
            mu[0]     = 10'sd0;
            mu[1]     = 10'sd0;
            logvar[0] = 10'sd300;
            logvar[1] = -10'sd300;
            sample_en = ~se;
        end
        for (int i = 0; i < 20 && finish !== 1'b1; i++) @(negedge clk);
        checkOutput({name, "_finish_seen"}, int'(finish === 1'b1), 1);
        if (mode == 2) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checkOutput({name, "_finish_held"}, int'(finish), 1);
            end
            checkOutput({name, "_z0_held"}, int'(z[0]), int'(e0));
        end
        enable = 1'b0;
        @(negedge clk);
        checkOutput({name, "_finish_cleared"}, int'(finish), 0);
        if (mode != 0) begin
            @(negedge clk);
            checkOutput({name, "_idle_z1_held"}, int'(z[1]), int'(e1));
            checkOutput({name, "_idle_finish_low"}, int'(finish), 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        enable    = 1'b0;
        sample_en = 1'b0;
        mu[0]     = '0;
        mu[1]     = '0;
        logvar[0] = '0;
        logvar[1] = '0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_z0", int'(z[0]), 0);
        checkOutput("reset_z1", int'(z[1]), 0);
        checkOutput("reset_finish", int'(finish), 0);
        checkOutput("reset_lfsr", int'(dut.lfsr_q), 16'hACE1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] eval mode");
        applyStimulus("eval", 10'sd16, -10'sd40, 10'sd0, 10'sd0, 1'b0, 10'sd16, -10'sd40, 0);
        checkOutput("eval_lfsr_hold", int'(dut.lfsr_q), 16'hACE1);

        $display("[TB] stochastic, enable dropped mid-run");
        applyStimulus("stoch", -10'sd100, 10'sd50, 10'sd0, 10'sd20, 1'b1, -10'sd93, 10'sd48, 1);
        checkOutput("stoch_lfsr_adv", int'(dut.lfsr_q), 16'hB387);

        $display("[TB] saturation and high LUT clamp, enable held");
        doReset();
        applyStimulus("sat", 10'sd510, -10'sd510, 10'sd0, 10'sd511, 1'b1, 10'sd511, -10'sd512, 2);

        $display("[TB] low LUT clamp");
        doReset();
        applyStimulus("lutlo", -10'sd200, 10'sd100, -10'sd512, -10'sd64, 1'b1, -10'sd200, 10'sd99, 0);

        $display("[TB] LFSR continues across runs");
        applyStimulus("cont", 10'sd0, 10'sd0, -10'sd3, 10'sd40, 1'b1, -10'sd1, -10'sd7, 0);

        $display("[TB] reset mid-run");
        doReset();
        @(negedge clk);
        mu[0]     = -10'sd100;
        mu[1]     = 10'sd50;
        logvar[0] = 10'sd0;
        logvar[1] = 10'sd20;
        sample_en = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrun_z0_before", int'(z[0]), -93);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun_z0", int'(z[0]), 0);
        checkOutput("midrun_z1", int'(z[1]), 0);
        checkOutput("midrun_finish", int'(finish), 0);
        checkOutput("midrun_lfsr", int'(dut.lfsr_q), 16'hACE1);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("rerun", -10'sd100, 10'sd50, 10'sd0, 10'sd20, 1'b1, -10'sd93, 10'sd48, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/vae_latent_sampler.md
Name: vae_latent_sampler

Overview:
- Encoder-side counterpart to the decoder layers: turns the encoder head outputs (mu, logvar per latent dimension) into the latent vector z that the first decoder layer consumes.
- Implements the reparameterisation z = mu + exp(logvar/2)*eps, with eps from an on-chip LFSR approximating a Gaussian.
- Processes one latent dimension per cycle and uses the same level enable/finish handshake as the dense layers.

Parameters:
- latent_number, 2, number of latent dimensions (array length of mu, logvar, z).
- width, 10, signed fixed-point word width of all data ports.
- frac_bits, 4, fractional bits F of the fixed-point format.
- seed, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'hACE1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start request, level; held high until finish is seen.
- sample_en  input  1  1 = stochastic (eps from LFSR); 0 = eval mode (eps = 0, z = mu).
- mu  input  signed [width-1:0] x [0:latent_number-1]  latent mean, unpacked array.
- logvar  input  signed [width-1:0] x [0:latent_number-1]  latent log-variance, unpacked array.
- z  output  signed [width-1:0] x [0:latent_number-1]  sampled latent, registered.
- finish  output  1  result valid, registered level.

Behaviour:
- Reset, asynchronous: FSM=IDLE, idx=0, all z=0, finish=0, lfsr=seed, latched mu/logvar=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: when enable=1 at a clock edge, latch mu, logvar and sample_en into internal registers, set idx=0 and go to RUN. Inputs may change after this edge.
- RUN: each cycle compute dimension idx and register z[idx].
  - If idx==latent_number-1, go to DONE and set finish=1.
  - Otherwise idx++.
  - enable is ignored in RUN; dropping it mid-RUN does not abort the run.
- DONE: finish=1 and z are held while enable=1. When enable=0, go to IDLE and clear finish (registered). z is held until the next run overwrites it.
- Latency: enable sampled high at edge k gives finish=1 after edge k+1+latent_number. Example: latent_number=2, enable high at edge 0, finish visible after edge 3.
- eps generation:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit inserted at bit 0.
  - eps = (nibble3+nibble2+nibble1+nibble0) - 30, computed from the current LFSR state. Range is -30..30, interpreted as Q.F.
  - The LFSR advances once per processed dimension, only when latched sample_en=1.
  - When latched sample_en=0: eps=0 and the LFSR does not advance.
- sigma:
  - h = logvar >>> 1 (arithmetic), clamped to [-32, 31].
  - sigma = round(2^F * exp(h / 2^F)), saturated to 2^(width-1)-1. Always >= 0.
  - Produced by the LUT sub-module.
- z arithmetic:
  - prod = sigma * eps at full width (width+7 bits, signed).
  - t = prod >>> F (arithmetic shift, truncation toward minus infinity).
  - z[idx] = sat(mu[idx] + t) to [-2^(width-1), 2^(width-1)-1].
  - No intermediate wrap-around is permitted.
- Reset mid-RUN: immediate return to reset values; the partially written z is discarded and set to zero.
- enable held high continuously: after DONE->IDLE requires enable=0, so a new run needs a low phase on enable.

Decomposition:
- Shared package vae_pkg:
  - fixed-point constants (WIDTH, FRAC_BITS);
  - LFSR polynomial mask and default seed;
  - the EPS_OFFSET=30 constant;
  - a sat_add function reused by the dense layers.
- Sub-module vae_sigma_lut:
  - combinational, 64-entry ROM indexed by clamped h;
  - parameters width and frac_bits;
  - table generated from the sigma formula.

Test Plan:
- Eval mode: sample_en=0, mu={16,-40}, logvar={0,0}, enable high at edge 0 -> z={16,-40}; finish rises after edge 3; LFSR still 16'hACE1.
- Stochastic, first dimension: sample_en=1, seed ACE1, mu[0]=-100, logvar[0]=0 -> sigma=16, eps=10+12+14+1-30=7, z[0]=-93. z[1] must match the reference model using the advanced LFSR state.
- Saturation: sample_en=1, mu[0]=510, logvar[0]=0 -> z[0]=511, not wrapped. Repeat with negative eps reaching -512 and check it clamps at -512.
- LUT clamp: logvar[0]=-512 -> h clamped to -32, sigma=2. logvar[0]=511 -> h clamped to 31, sigma=111. z checked against the model.
- Handshake: enable dropped at edge 1 mid-RUN -> run completes; finish high for exactly one cycle, then IDLE. With enable held high, finish stays high and no second run starts until enable toggles low.
- Reset mid-RUN: rst_n asserted between edges 1 and 2 -> z=0, finish=0 and lfsr=seed immediately, without waiting for a clock edge. A subsequent run reproduces the first-run results exactly.
